// File: rtl/types.sv
// Shared flit definitions for the NoC receive path: the flit word, its field positions,
// type encodings and the payload checksum.
package types;

  typedef logic [63:0] flit_t;

  localparam int unsigned TypeMsb    = 63;
  localparam int unsigned TypeLsb    = 62;
  localparam int unsigned IdMsb      = 61;
  localparam int unsigned IdLsb      = 58;
  localparam int unsigned CsumMsb    = 57;
  localparam int unsigned CsumLsb    = 50;
  localparam int unsigned PayloadMsb = 49;
  localparam int unsigned PayloadLsb = 0;

  typedef enum logic [1:0] {
    FlitHead = 2'b00,
    FlitBody = 2'b01,
    FlitTail = 2'b10,
    FlitNope = 2'b11
  } flit_type_e;

  function automatic flit_type_e flit_type(input flit_t f);
    return flit_type_e'(f[TypeMsb:TypeLsb]);
  endfunction

  function automatic logic [3:0] flit_id(input flit_t f);
    return f[IdMsb:IdLsb];
  endfunction

  function automatic logic [7:0] flit_csum(input flit_t f);
    return f[CsumMsb:CsumLsb];
  endfunction

  function automatic logic [49:0] flit_payload(input flit_t f);
    return f[PayloadMsb:PayloadLsb];
  endfunction

  // XOR of the seven bytes of the payload zero-extended to 56 bits.
  function automatic logic [7:0] checksum(input logic [49:0] payload);
    logic [55:0] wide;
    logic [7:0]  acc;
    wide = {6'b0, payload};
    acc  = '0;
    for (int i = 0; i < 7; i++) begin
      acc ^= wide[8*i +: 8];
    end
    return acc;
  endfunction

endpackage

// File: rtl/flit_pipe_reg.sv
// Single-entry output register with skid-free ready: accepts a new flit on the same edge the
// held one is taken downstream.
module flit_pipe_reg
  import types::*;
(
  input  logic  clk_i,
  input  logic  rst_i,
  input  flit_t in_flit_i,
  input  logic  in_push_i,
  output logic  in_ready_o,
  output flit_t out_flit_o,
  output logic  out_valid_o,
  input  logic  out_ready_i
);

  flit_t flit_q, flit_d;
  logic  valid_q, valid_d;

  assign in_ready_o  = !rst_i && (!valid_q || out_ready_i);
  assign out_flit_o  = flit_q;
  assign out_valid_o = valid_q;

  always_comb begin
    flit_d  = flit_q;
    valid_d = valid_q;
    if (in_push_i) begin
      flit_d  = in_flit_i;
      valid_d = 1'b1;
    end else if (out_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      flit_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      flit_q  <= flit_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/packet_receiver.sv
// Link-side packet receiver: validates flit ordering, forwards good flits through one output
// register and counts errors. Define PACKET_RECEIVER_CHECKSUM_EN to enable payload checksum checks.
module packet_receiver
  import types::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        nocclk,
  input  logic        rst,
  input  flit_t       received_flit,
  input  logic        received_flit_valid,
  output logic        received_flit_ready,
  output flit_t       transfered_flit,
  output logic        transfered_flit_valid,
  input  logic        transfered_flit_ready,
  output flit_t       transfered_head_flit,
  output logic        packet_error,
  output logic [7:0]  error_count
);

  typedef enum logic [1:0] {StIdle, StInPacket, StDrop} state_e;

  state_e     state_q, state_d;
  logic [3:0] exp_id_q, exp_id_d;
  logic [7:0] idle_cnt_q, idle_cnt_d;
  flit_t      head_q, head_d;
  logic       perr_q, perr_d;
  logic [7:0] err_cnt_q, err_cnt_d;

  logic       accept, fwd, start, err, csum_ok, push;
  flit_type_e ftype;
  logic [3:0] fid;
  logic [8:0] idle_inc;

  assign accept   = received_flit_valid && received_flit_ready;
  assign ftype    = flit_type(received_flit);
  assign fid      = flit_id(received_flit);
  assign idle_inc = {1'b0, idle_cnt_q} + 9'd1;
  assign push     = accept && fwd;

`ifdef PACKET_RECEIVER_CHECKSUM_EN
  assign csum_ok = (flit_csum(received_flit) == checksum(flit_payload(received_flit)));
`else
  assign csum_ok = 1'b1;
`endif

  always_comb begin
    state_d    = state_q;
    exp_id_d   = exp_id_q;
    idle_cnt_d = '0;
    head_d     = head_q;
    fwd        = 1'b0;
    start      = 1'b0;
    err        = 1'b0;
    if (accept && ftype != FlitNope) begin
      if (!csum_ok) begin
        err     = 1'b1;
        state_d = (ftype == FlitBody) ? StDrop : StIdle;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (ftype == FlitHead && fid == 4'd0) start = 1'b1;
            else err = 1'b1;
          end
          StInPacket: begin
            unique case (ftype)
              FlitHead: begin
                err = 1'b1;
                if (fid == 4'd0) start = 1'b1;
                else state_d = StIdle;
              end
              FlitBody, FlitTail: begin
                if (fid == exp_id_q) begin
                  fwd      = 1'b1;
                  exp_id_d = exp_id_q + 4'd1;
                  if (ftype == FlitTail) state_d = StIdle;
                end else begin
                  err     = 1'b1;
                  state_d = StDrop;
                end
              end
              default: ;
            endcase
          end
          StDrop: begin
            if (ftype == FlitHead) begin
              if (fid == 4'd0) start = 1'b1;
              else state_d = StIdle;
            end else if (ftype == FlitTail) begin
              state_d = StIdle;
            end
          end
          default: state_d = StIdle;
        endcase
      end
    end else if (state_q == StInPacket) begin
      // NOPEs and empty cycles both age the packet.
      if (idle_inc == 9'(TIMEOUT_CYCLES)) begin
        err     = 1'b1;
        state_d = StIdle;
      end else begin
        idle_cnt_d = idle_inc[7:0];
      end
    end
    if (start) begin
      fwd      = 1'b1;
      head_d   = received_flit;
      exp_id_d = 4'd1;
      state_d  = StInPacket;
    end
    perr_d    = err;
    err_cnt_d = (err && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
  end

  always_ff @(posedge nocclk) begin
    if (rst) begin
      state_q    <= StIdle;
      exp_id_q   <= '0;
      idle_cnt_q <= '0;
      head_q     <= '0;
      perr_q     <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      exp_id_q   <= exp_id_d;
      idle_cnt_q <= idle_cnt_d;
      head_q     <= head_d;
      perr_q     <= perr_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign transfered_head_flit = head_q;
  assign packet_error         = perr_q;
  assign error_count          = err_cnt_q;

  flit_pipe_reg u_pipe (
    .clk_i       (nocclk),
    .rst_i       (rst),
    .in_flit_i   (received_flit),
    .in_push_i   (push),
    .in_ready_o  (received_flit_ready),
    .out_flit_o  (transfered_flit),
    .out_valid_o (transfered_flit_valid),
    .out_ready_i (transfered_flit_ready)
  );

endmodule

// File: tb/tb_packet_receiver.sv
// Bench for packet_receiver: directed scenarios with literal expectations plus randomized
// traffic checked every cycle against a rule-level reference model.
module tb_packet_receiver;
  import types::*;

  localparam int TMO = 255;
  localparam int TH = 0, TB = 1, TT = 2, TN = 3;
  localparam int MIdle = 0, MIn = 1, MDrop = 2;

  logic       nocclk = 1'b0;
  logic       rst = 1'b1;
  flit_t      rf = '0;
  logic       rv = 1'b0;
  logic       ordy = 1'b1;
  logic       received_flit_ready;
  flit_t      transfered_flit;
  logic       transfered_flit_valid;
  flit_t      transfered_head_flit;
  logic       packet_error;
  logic [7:0] error_count;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int last_acc = 0;
  int perr_seen = 0;
  flit_t outq[$];
  int    outc[$];

  packet_receiver #(.TIMEOUT_CYCLES(TMO)) dut (
    .nocclk                (nocclk),
    .rst                   (rst),
    .received_flit         (rf),
    .received_flit_valid   (rv),
    .received_flit_ready   (received_flit_ready),
    .transfered_flit       (transfered_flit),
    .transfered_flit_valid (transfered_flit_valid),
    .transfered_flit_ready (ordy),
    .transfered_head_flit  (transfered_head_flit),
    .packet_error          (packet_error),
    .error_count           (error_count)
  );

  always #5 nocclk = ~nocclk;
  always @(posedge nocclk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] csum(input logic [49:0] p);
    logic [55:0] w;
    logic [7:0]  x;
    w = {6'b0, p};
    x = 8'h00;
    for (int i = 0; i < 7; i++) x ^= w[8*i +: 8];
    return x;
  endfunction

  function automatic flit_t mk(input int ty, input int id, input logic [49:0] p, input bit bad);
    logic [7:0] c;
    c = csum(p);
    if (bad) c ^= 8'hA5;
    return {ty[1:0], id[3:0], c, p};
  endfunction

  // Receiver rules for one accepted flit, stated per (mode, type).
  function automatic void rules(input int mode, input int ty, input int id, input int expid,
                                input bit csok, output bit fwd, output bit err, output bit start,
                                output int nmode);
    fwd = 0; err = 0; start = 0; nmode = mode;
    if (ty == TN) return;
    if (!csok) begin
      err = 1;
      nmode = (ty == TB) ? MDrop : MIdle;
      return;
    end
    if (ty == TH) begin
      err = (mode == MIn) || (mode == MIdle && id != 0);
      if (id == 0) begin fwd = 1; start = 1; nmode = MIn; end
      else nmode = MIdle;
    end else if (mode == MIdle) begin
      err = 1;
    end else if (mode == MIn) begin
      if (id == expid) begin fwd = 1; nmode = (ty == TT) ? MIdle : MIn; end
      else begin err = 1; nmode = MDrop; end
    end else if (ty == TT) begin
      nmode = MIdle;
    end
  endfunction

  // Reference model state.
  int    m_mode, m_exp, m_idle, m_cnt;
  bit    m_valid, m_perr;
  flit_t m_flit, m_head;

  always @(posedge nocclk) begin
    bit acc, fwd, err, start, nonnope, csok;
    int nmode, ty, id;
    if (rst) begin
      m_mode = MIdle; m_exp = 0; m_idle = 0; m_cnt = 0;
      m_valid = 0; m_perr = 0; m_flit = '0; m_head = '0;
    end else begin
      acc = rv && (!m_valid || ordy);
      if (m_valid && ordy) m_valid = 0;
      ty = int'(rf[63:62]);
      id = int'(rf[61:58]);
      csok = 1;
`ifdef PACKET_RECEIVER_CHECKSUM_EN
      csok = (rf[57:50] == csum(rf[49:0]));
`endif
      fwd = 0; err = 0; start = 0; nmode = m_mode;
      if (acc) rules(m_mode, ty, id, m_exp, csok, fwd, err, start, nmode);
      nonnope = acc && (ty != TN);
      if (m_mode == MIn && !nonnope) begin
        m_idle++;
        if (m_idle == TMO) begin err = 1; nmode = MIdle; end
      end
      if (nmode != MIn || nonnope) m_idle = 0;
      if (fwd) begin m_valid = 1; m_flit = rf; end
      if (start) begin m_head = rf; m_exp = 1; end
      else if (fwd && ty == TB) m_exp = (m_exp + 1) % 16;
      m_mode = nmode;
      m_perr = err;
      if (err && m_cnt < 255) m_cnt++;
    end
  end

  // Per-cycle comparison and output monitor.
  always @(negedge nocclk) begin
    chk("rx_ready", {63'b0, received_flit_ready}, {63'b0, !rst && (!m_valid || ordy)});
    chk("tx_valid", {63'b0, transfered_flit_valid}, {63'b0, m_valid});
    if (m_valid) chk("tx_flit", transfered_flit, m_flit);
    chk("head_flit", transfered_head_flit, m_head);
    chk("packet_error", {63'b0, packet_error}, {63'b0, m_perr});
    chk("error_count", {56'b0, error_count}, 64'(m_cnt));
    if (!rst && transfered_flit_valid === 1'b1 && ordy) begin
      outq.push_back(transfered_flit);
      outc.push_back(cyc);
    end
    if (packet_error === 1'b1) perr_seen++;
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge nocclk); #2; end
  endtask

  task automatic send(input flit_t f);
    int n;
    bit got;
    rf = f; rv = 1'b1; n = 0; got = 0;
    while (!got && n < 100) begin
      @(negedge nocclk);
      if (received_flit_ready === 1'b1) begin got = 1; last_acc = cyc + 1; end
      @(posedge nocclk); #2;
      n++;
    end
    rv = 1'b0;
    if (!got) begin
      n_checks++; n_errors++;
      $display("FAIL send_accept: got no acceptance expected acceptance within 100 cycles");
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; rv = 1'b0; ordy = 1'b1;
    step(1);
    @(negedge nocclk);
    chk("rst_ready_low", {63'b0, received_flit_ready}, 64'd0);
    step(1);
    rst = 1'b0;
    @(negedge nocclk);
    chk("rst_valid", {63'b0, transfered_flit_valid}, 64'd0);
    chk("rst_flit", transfered_flit, 64'd0);
    chk("rst_head", transfered_head_flit, 64'd0);
    chk("rst_perr", {63'b0, packet_error}, 64'd0);
    chk("rst_count", {56'b0, error_count}, 64'd0);
    outq.delete(); outc.delete(); perr_seen = 0;
    step(1);
  endtask

  initial begin
    flit_t h, b, t, bad_h;
    int acc_h, gen_id, r;
    logic [63:0] rnd;

    // Back-to-back HEAD/BODY/TAIL.
    do_reset();
    h = mk(TH, 0, 50'h1234_5678_9AB, 0);
    b = mk(TB, 1, 50'h0F0F_0F0F_0F0, 0);
    t = mk(TT, 2, 50'h3_FFFF_FFFF_FFFF, 0);
    send(h); acc_h = last_acc;
    send(b); send(t); step(3);
    chk("basic_n_out", 64'(outq.size()), 64'd3);
    if (outq.size() == 3) begin
      chk("basic_out0", outq[0], h);
      chk("basic_out1", outq[1], b);
      chk("basic_out2", outq[2], t);
      chk("basic_lat0", 64'(outc[0]), 64'(acc_h));
      chk("basic_lat1", 64'(outc[1]), 64'(acc_h + 1));
      chk("basic_lat2", 64'(outc[2]), 64'(acc_h + 2));
    end
    chk("basic_head", transfered_head_flit, h);
    chk("basic_errcnt", {56'b0, error_count}, 64'd0);

    // Downstream stall with a BODY waiting.
    do_reset();
    send(h);
    ordy = 1'b0;
    rf = b; rv = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge nocclk);
      chk("stall_flit", transfered_flit, h);
      chk("stall_valid", {63'b0, transfered_flit_valid}, 64'd1);
      chk("stall_rx_ready", {63'b0, received_flit_ready}, 64'd0);
    end
    step(1);
    ordy = 1'b1;
    send(b); step(3);
    chk("stall_n_out", 64'(outq.size()), 64'd2);
    if (outq.size() == 2) chk("stall_body", outq[1], b);

    // Wrong ids inside a packet.
    do_reset();
    send(h);
    send(mk(TB, 3, 50'h11, 0));
    send(mk(TB, 2, 50'h22, 0));
    send(mk(TT, 3, 50'h33, 0));
    step(3);
    chk("seq_n_out", 64'(outq.size()), 64'd1);
    chk("seq_pulses", 64'(perr_seen), 64'd1);
    chk("seq_errcnt", {56'b0, error_count}, 64'd1);
    send(mk(TB, 0, 50'h44, 0)); step(2);
    chk("seq_idle_after", {56'b0, error_count}, 64'd2);

    // 18-flit packet wrapping the id.
    do_reset();
    send(h);
    for (int i = 1; i <= 16; i++) send(mk(TB, i % 16, 50'(i * 977), 0));
    send(mk(TT, 1, 50'h5A5A, 0));
    step(3);
    chk("wrap_n_out", 64'(outq.size()), 64'd18);
    chk("wrap_errcnt", {56'b0, error_count}, 64'd0);

    // Timeout after 255 idle cycles.
    do_reset();
    send(h);
    step(254);
    @(negedge nocclk);
    chk("tmo_before", {56'b0, error_count}, 64'd0);
    step(1);
    @(negedge nocclk);
    chk("tmo_count", {56'b0, error_count}, 64'd1);
    chk("tmo_pulse", {63'b0, packet_error}, 64'd1);
    step(1);
    send(b); step(2);
    chk("tmo_body_err", {56'b0, error_count}, 64'd2);
    chk("tmo_n_out", 64'(outq.size()), 64'd1);

    // Corrupted checksum on a HEAD.
    do_reset();
    bad_h = mk(TH, 0, 50'h2_DEAD_BEEF_0001, 1);
    send(bad_h); step(3);
`ifdef PACKET_RECEIVER_CHECKSUM_EN
    chk("csum_n_out", 64'(outq.size()), 64'd0);
    chk("csum_errcnt", {56'b0, error_count}, 64'd1);
`else
    chk("csum_n_out", 64'(outq.size()), 64'd1);
    chk("csum_errcnt", {56'b0, error_count}, 64'd0);
`endif

    // Error counter saturation.
    do_reset();
    for (int i = 0; i < 260; i++) send(mk(TB, 0, 50'(i), 0));
    step(2);
    chk("sat_errcnt", {56'b0, error_count}, 64'd255);

    // Randomized traffic with random backpressure and occasional resets.
    do_reset();
    gen_id = 0;
    for (int i = 0; i < 4000; i++) begin
      rst  = ($urandom_range(0, 999) < 3);
      ordy = ($urandom_range(0, 3) != 0);
      rv   = ($urandom_range(0, 3) != 0);
      rnd  = {$urandom(), $urandom()};
      r    = $urandom_range(0, 99);
      if (r < 10) begin
        rf = mk(TH, 0, rnd[49:0], 0); gen_id = 1;
      end else if (r < 14) begin
        rf = mk(TH, $urandom_range(0, 15), rnd[49:0], 0);
      end else if (r < 70) begin
        rf = mk(TB, gen_id, rnd[49:0], 0); gen_id = (gen_id + 1) % 16;
      end else if (r < 80) begin
        rf = mk(TT, gen_id, rnd[49:0], 0);
      end else if (r < 87) begin
        rf = mk(TN, $urandom_range(0, 15), rnd[49:0], 0);
      end else begin
        rf = mk($urandom_range(1, 2), $urandom_range(0, 15), rnd[49:0], r > 96);
      end
      step(1);
    end
    rst = 1'b0; rv = 1'b0; ordy = 1'b1;
    step(5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/packet_receiver.md
PACKET_RECEIVER -- requirements
Module: packet_receiver

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, the number of idle cycles inside a packet before that packet is aborted.
REQ-002 SHALL have port nocclk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port received_flit, input, types::flit_t: a flit arriving from the link.
REQ-005 SHALL have port received_flit_valid, input, 1 bit, and port received_flit_ready, output, 1 bit: a flit is accepted when both are high at the same edge.
REQ-006 SHALL have port transfered_flit, output, types::flit_t, port transfered_flit_valid, output, 1 bit, and port transfered_flit_ready, input, 1 bit: the flit stream to the router.
REQ-007 SHALL have port transfered_head_flit, output, types::flit_t: the head flit of the packet currently being delivered.
REQ-008 SHALL have port packet_error, output, 1 bit: a one-cycle pulse on any error.
REQ-009 SHALL have port error_count, output, 8 bits: a saturating count of errors.

Function
REQ-010 SHALL use this flit layout: [63:62] type (HEAD=00, BODY=01, TAIL=10, NOPE=11); [61:58] flit_id; [57:50] checksum; [49:0] payload.
REQ-011 SHALL hold exactly one output register, so an accepted flit is presented on transfered_flit starting the cycle after acceptance (latency 1).
REQ-012 SHALL hold transfered_flit stable while transfered_flit_valid is high and transfered_flit_ready is low.
REQ-013 SHALL drive received_flit_ready as (!transfered_flit_valid || transfered_flit_ready); a forwarded flit and a new acceptance on the same edge give full throughput.
REQ-014 SHALL consume discarded flits with no output and no bubble.
REQ-015 SHALL implement three states: IDLE, IN_PACKET and DROP, with IDLE as the reset state.
REQ-016 IDLE: a HEAD with flit_id 0 SHALL be forwarded and latched into transfered_head_flit; expected id becomes 1; next state IN_PACKET.
REQ-017 IDLE: a HEAD with flit_id not 0, or any BODY or TAIL, SHALL be discarded and counted as an error; state stays IDLE.
REQ-018 IN_PACKET: a BODY with the expected id SHALL be forwarded and the expected id incremented modulo 16 (15 wraps to 0).
REQ-019 IN_PACKET: a TAIL with the expected id SHALL be forwarded; next state IDLE.
REQ-020 IN_PACKET: a BODY or TAIL with the wrong id SHALL be discarded and counted as an error; next state DROP.
REQ-021 IN_PACKET or DROP: a HEAD SHALL be counted as an error only in IN_PACKET, then handled exactly as in REQ-016 (restart); a HEAD with flit_id not 0 SHALL be discarded and lead to IDLE.
REQ-022 DROP: a BODY SHALL be discarded; a TAIL SHALL be discarded and lead to IDLE; neither counts as an error.
REQ-023 NOPE flits SHALL be accepted and discarded in every state, with no change of state, no error, and no reset of the timeout counter.
REQ-024 Timeout: an 8-bit counter SHALL count cycles in IN_PACKET with no non-NOPE acceptance, clearing on every such acceptance.
REQ-025 Timeout: when the counter reaches TIMEOUT_CYCLES, next state SHALL be IDLE, an error SHALL be counted, and the counter SHALL clear.
REQ-026 Each error SHALL give a packet_error pulse on the next cycle and increment error_count, which saturates at 255.
REQ-027 transfered_head_flit SHALL change only on an accepted HEAD that is forwarded.

Reset
REQ-028 While rst is high on an edge, the block SHALL enter IDLE and clear transfered_flit, transfered_flit_valid, transfered_head_flit, packet_error, error_count and the timeout counter to 0.
REQ-029 received_flit_ready SHALL be 0 while rst is high.
REQ-030 A flit held in the output register when reset is asserted mid-operation SHALL be lost, with valid low on the cycle after the reset edge.

Configuration
REQ-031 With PACKET_RECEIVER_CHECKSUM_EN defined, the checksum field SHALL be checked against the XOR of the 7 bytes of the payload zero-extended to 56 bits.
REQ-032 With PACKET_RECEIVER_CHECKSUM_EN defined, a mismatch SHALL count as an error and discard the flit: a HEAD leads to IDLE, a BODY to DROP, a TAIL to IDLE.
REQ-033 With PACKET_RECEIVER_CHECKSUM_EN undefined, the checksum field SHALL be ignored and no checksum logic synthesized.

Structure
REQ-034 The flit type encodings, field bit positions and the CHECKSUM function SHALL live in the shared types package, next to flit_t.
REQ-035 The state enum SHALL be local to the module.
REQ-036 The output register and ready logic SHALL be one sub-module, flit_pipe_reg.

Verification
REQ-037 A bench SHALL cover: HEAD(id0), BODY(id1), TAIL(id2), with ready held at 1 -> three flits out at cycles N+1, N+2 and N+3; transfered_head_flit equals the HEAD from N+1; error_count is 0.
REQ-038 A bench SHALL cover: transfered_flit_ready held at 0 for 4 cycles with a BODY pending -> transfered_flit stable, received_flit_ready 0, and no flit lost after release.
REQ-039 A bench SHALL cover: HEAD(id0), BODY(id3), BODY(id2), TAIL(id3) -> only the HEAD is forwarded; one packet_error pulse; error_count is 1; state IDLE afterwards.
REQ-040 A bench SHALL cover: a packet of 18 flits (id wraps 15 -> 0 -> 1) -> all 18 flits forwarded with no error.
REQ-041 A bench SHALL cover: HEAD then 255 idle cycles (with TIMEOUT_CYCLES=255) -> one error; a following BODY is discarded and counted as an error (error_count 2).
REQ-042 A bench SHALL cover, with PACKET_RECEIVER_CHECKSUM_EN defined: a HEAD with a corrupted checksum -> no output, error_count 1; without the macro, the same stimulus is forwarded.
